// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types, constants and helpers for the execute-stage multiply/divide unit.
package muldiv_pkg;
  localparam int XLEN = 32;
  localparam int MULDIV_ITERS = 32;
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_t;
  typedef enum logic [1:0] {IDLE, CALC, DONE} muldiv_state_t;
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic s);
    return s ? -v : v;
  endfunction
  function automatic logic [63:0] neg64(input logic [63:0] v, input logic n);
    return n ? -v : v;
  endfunction
endpackage

// File: rtl/muldiv_restoring_div.sv
// muldiv_restoring_div: one shift-subtract step of the unsigned restoring divider.
module muldiv_restoring_div (
  input  logic [31:0] rem_i,
  input  logic [31:0] quo_i,
  input  logic [31:0] div_i,
  output logic [31:0] rem_o,
  output logic [31:0] quo_o
);
  logic [32:0] sh;
  logic ge;
  assign sh = {rem_i, quo_i[31]};
  assign ge = sh >= {1'b0, div_i};
  assign rem_o = ge ? 32'(sh - {1'b0, div_i}) : sh[31:0];
  assign quo_o = {quo_i[30:0], ge};
endmodule

// File: rtl/execute_muldiv_unit.sv
// execute_muldiv_unit: iterative RV32M multiply/divide in the execute stage, stalling the front end while busy.
// Define MULDIV_FAST_MUL_EN to replace the shift-add multiply with a single-cycle 33x33 multiplier.
module execute_muldiv_unit
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            MulDivStartE,
  input  logic [2:0]      MulDivOpE,
  input  logic [XLEN-1:0] SrcAE,
  input  logic [XLEN-1:0] SrcBE,
  input  logic            FlushE,
  output logic            MulDivStallE,
  output logic            MulDivDoneE,
  output logic [XLEN-1:0] MulDivResultE
);
  muldiv_state_t state_q, state_d;
  muldiv_op_t op_q, op_d, op;
  logic [4:0] cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d, step, fix;
  logic [31:0] opb_q, opb_d, res_q, res_d, fast_res, div_fast_res, rem_nxt, quo_nxt;
  logic neg_q, neg_d, done_q, done_d, sgn_a, sgn_b, sa, sb, div_zero, div_ovf, fast;
  logic [32:0] sum;
  assign op = muldiv_op_t'(MulDivOpE);
  assign sgn_a = !(op inside {OP_MULHU, OP_DIVU, OP_REMU});
  assign sgn_b = sgn_a && op != OP_MULHSU;
  assign sa = sgn_a & SrcAE[31];
  assign sb = sgn_b & SrcBE[31];
  assign div_zero = op[2] && SrcBE == '0;
  assign div_ovf = op[2] && !op[0] && SrcAE == 32'h8000_0000 && SrcBE == '1;
  assign div_fast_res = div_zero ? (op[1] ? SrcAE : '1) : (op[1] ? '0 : 32'h8000_0000);
`ifdef MULDIV_FAST_MUL_EN
  logic [63:0] fm;
  assign fm = 64'($signed({sa, SrcAE})) * 64'($signed({sb, SrcBE}));
  assign fast = div_zero | div_ovf | !op[2];
  assign fast_res = op[2] ? div_fast_res : (op == OP_MUL ? fm[31:0] : fm[63:32]);
`else
  assign fast = div_zero | div_ovf;
  assign fast_res = div_fast_res;
`endif
  // Multiply and divide share acc_q: {partial product, multiplier} or {remainder, quotient}.
  assign sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
  muldiv_restoring_div u_div (
    .rem_i(acc_q[63:32]),
    .quo_i(acc_q[31:0]),
    .div_i(opb_q),
    .rem_o(rem_nxt),
    .quo_o(quo_nxt)
  );
  assign step = op_q[2] ? {rem_nxt, quo_nxt} : {sum, acc_q[31:1]};
  assign fix = neg64(op_q[2] ? {32'd0, op_q[1] ? step[63:32] : step[31:0]} : step, neg_q);
  assign MulDivStallE = rst & ~FlushE & ((state_q == IDLE & MulDivStartE) | state_q == CALC);
  assign MulDivDoneE = done_q;
  assign MulDivResultE = res_q;
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    opb_d = opb_q;
    neg_d = neg_q;
    res_d = res_q;
    done_d = 1'b0;
    if (FlushE) state_d = IDLE;
    else
      case (state_q)
        IDLE: if (MulDivStartE) begin
          op_d = op;
          if (fast) begin
            state_d = DONE;
            res_d = fast_res;
            done_d = 1'b1;
          end else begin
            state_d = CALC;
            cnt_d = 5'(MULDIV_ITERS - 1);
            acc_d = {32'd0, abs32(SrcAE, sa)};
            opb_d = abs32(SrcBE, sb);
            neg_d = op[2] && op[1] ? sa : sa ^ sb;
          end
        end
        CALC: begin
          acc_d = step;
          cnt_d = cnt_q - 5'd1;
          if (cnt_q == '0) begin
            state_d = DONE;
            res_d = (op_q[2] || op_q == OP_MUL) ? fix[31:0] : fix[63:32];
            done_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      op_q <= OP_MUL;
      cnt_q <= '0;
      acc_q <= '0;
      opb_q <= '0;
      neg_q <= 1'b0;
      res_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      opb_q <= opb_d;
      neg_q <= neg_d;
      res_q <= res_d;
      done_q <= done_d;
    end
  end
endmodule

// File: tb/tb_execute_muldiv_unit.sv
// tb_execute_muldiv_unit: scoreboard bench with directed test-plan cases and randomized ops against an arithmetic model.
module tb_execute_muldiv_unit;
  logic clk = 1'b0, rst = 1'b0, MulDivStartE = 1'b0, FlushE = 1'b0;
  logic [2:0] MulDivOpE = '0;
  logic [31:0] SrcAE = '0, SrcBE = '0;
  logic MulDivStallE, MulDivDoneE;
  logic [31:0] MulDivResultE;
  int checks = 0, failures = 0, cyc = 0;
  logic [31:0] exp_q[$];
  int cyc_q[$];
  logic [31:0] mon_e;
  int mon_c;
  execute_muldiv_unit dut (
    .clk(clk),
    .rst(rst),
    .MulDivStartE(MulDivStartE),
    .MulDivOpE(MulDivOpE),
    .SrcAE(SrcAE),
    .SrcBE(SrcBE),
    .FlushE(FlushE),
    .MulDivStallE(MulDivStallE),
    .MulDivDoneE(MulDivDoneE),
    .MulDivResultE(MulDivResultE)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'd0, a});
    longint ub = longint'({32'd0, b});
    logic [63:0] p;
    logic ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: return b == 0 ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
      3'd5: return b == 0 ? 32'hFFFF_FFFF : a / b;
      3'd6: return b == 0 ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
      default: return b == 0 ? a : a % b;
    endcase
  endfunction
  function automatic int lat_of(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!op[2]) return 1;
`endif
    return 33;
  endfunction
  // Called #1 after a rising edge; returns #1 after the edge that ends the DONE cycle.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    int lat = lat_of(op, a, b);
    int n = 0;
    exp_q.push_back(exp);
    cyc_q.push_back(cyc + lat);
    MulDivStartE = 1'b1;
    MulDivOpE = op;
    SrcAE = a;
    SrcBE = b;
    @(negedge clk);
    while (MulDivStallE && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("stall_cycles", 32'(n), 32'(lat));
    @(posedge clk);
    #1 MulDivStartE = 1'b0;
  endtask
  always @(negedge clk)
    if (rst && MulDivDoneE) begin
      if (exp_q.size() == 0) check("unexpected_done", {31'd0, MulDivDoneE}, 32'd0);
      else begin
        mon_e = exp_q.pop_front();
        mon_c = cyc_q.pop_front();
        check("result", MulDivResultE, mon_e);
        check("done_cycle", 32'(cyc), 32'(mon_c));
      end
    end
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    logic [2:0] op;
    logic [31:0] a, b;
    #2;
    check("reset_done", {31'd0, MulDivDoneE}, 32'd0);
    check("reset_result", MulDivResultE, 32'd0);
    check("reset_stall", {31'd0, MulDivStallE}, 32'd0);
    #10 rst = 1'b1;
    @(posedge clk);
    #1;
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run_op(3'd5, 32'd100, 32'd7, 32'd14);
    run_op(3'd7, 32'd100, 32'd7, 32'd2);
    run_op(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF);
    run_op(3'd6, 32'd5, 32'd0, 32'd5);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    // Flush a divide at cycle 10; it must never report DONE.
    MulDivStartE = 1'b1;
    MulDivOpE = 3'd4;
    SrcAE = 32'd1000;
    SrcBE = 32'd3;
    repeat (10) @(posedge clk);
    #1 FlushE = 1'b1;
    @(negedge clk);
    check("flush_stall", {31'd0, MulDivStallE}, 32'd0);
    @(posedge clk);
    #1 FlushE = 1'b0;
    MulDivStartE = 1'b0;
    @(negedge clk);
    check("idle_after_flush", {31'd0, MulDivStallE}, 32'd0);
    @(posedge clk);
    #1 run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    // Asynchronous reset in the middle of a divide.
    MulDivStartE = 1'b1;
    MulDivOpE = 3'd4;
    SrcAE = 32'd12345;
    SrcBE = 32'd17;
    repeat (15) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("async_rst_done", {31'd0, MulDivDoneE}, 32'd0);
    check("async_rst_result", MulDivResultE, 32'd0);
    check("async_rst_stall", {31'd0, MulDivStallE}, 32'd0);
    MulDivStartE = 1'b0;
    @(negedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 run_op(3'd5, 32'd100, 32'd7, 32'd14);
    for (int i = 0; i < 48; i++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: a = 32'h8000_0000;
        default: ;
      endcase
      run_op(op, a, b, model(op, a, b));
    end
    repeat (40) @(posedge clk);
    check("pending_results", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
